// File: rtl/u712_chip_cycle_seq.sv
// CPU-side chip bus cycle initiator: waits for a free 7 MHz slot, then drives
// CPU_CYCLE or REG_CYCLE for a fixed window with read-latch and done strobes.
module u712_chip_cycle_seq #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned ACTIVE_CLKS    = 16,
  parameter int unsigned MAX_WAIT_SLOTS = 8
) (
  input  logic CLK80,
  input  logic RESETn,
  input  logic C1,
  input  logic DBRn,
  input  logic CHIP_REQ,
  input  logic REG_REQ,
  input  logic RnW,
  output logic CPU_CYCLE,
  output logic REG_CYCLE,
  output logic CPU_RnW,
  output logic RD_LATCH,
  output logic DONE,
  output logic STARVE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACTIVE,
    S_LATCH,
    S_DONE
  } state_e;

  localparam logic [5:0] ACT_LAST = 6'(ACTIVE_CLKS - 1);
  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT_SLOTS);

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] c1_sync_q, dbr_sync_q;
  logic [SYNC_STAGES:0]   c1_shift, dbr_shift;
  logic                   c1_prev_q;
  logic                   slot;
  logic                   dbr_free;

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [5:0] act_cnt_q, act_cnt_d;
  logic       kind_reg_q, kind_reg_d;
  logic       rnw_q, rnw_d;
  logic       starve_q, starve_d;

  assign c1_shift  = {c1_sync_q, C1};
  assign dbr_shift = {dbr_sync_q, DBRn};
  assign slot      = c1_sync_q[SYNC_STAGES-1] & ~c1_prev_q;
  assign dbr_free  = dbr_sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK80 or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= S_IDLE;
      c1_sync_q  <= '0;
      dbr_sync_q <= '0;
      c1_prev_q  <= 1'b0;
      wait_cnt_q <= '0;
      act_cnt_q  <= '0;
      kind_reg_q <= 1'b0;
      rnw_q      <= 1'b0;
      starve_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      c1_sync_q  <= c1_shift[SYNC_STAGES-1:0];
      dbr_sync_q <= dbr_shift[SYNC_STAGES-1:0];
      c1_prev_q  <= c1_sync_q[SYNC_STAGES-1];
      wait_cnt_q <= wait_cnt_d;
      act_cnt_q  <= act_cnt_d;
      kind_reg_q <= kind_reg_d;
      rnw_q      <= rnw_d;
      starve_q   <= starve_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    act_cnt_d  = act_cnt_q;
    kind_reg_d = kind_reg_q;
    rnw_d      = rnw_q;
    starve_d   = starve_q;
    unique case (state_q)
      S_IDLE: begin
        if (REG_REQ || CHIP_REQ) begin
          kind_reg_d = REG_REQ;
          rnw_d      = RnW;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // Slot ownership is decided once, at the slot boundary.
        if (slot) begin
          if (dbr_free) begin
            act_cnt_d = '0;
            state_d   = S_ACTIVE;
          end else begin
            if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 8'd1;
            if (wait_cnt_d >= WAIT_MAX) starve_d = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        if (act_cnt_q == ACT_LAST) state_d = S_LATCH;
        else act_cnt_d = act_cnt_q + 6'd1;
      end
      S_LATCH: begin
        // Clear on the way into DONE so STARVE is already low with the DONE pulse.
        starve_d   = 1'b0;
        wait_cnt_d = '0;
        act_cnt_d  = '0;
        state_d    = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    CPU_CYCLE = 1'b0;
    REG_CYCLE = 1'b0;
    RD_LATCH  = 1'b0;
    DONE      = 1'b0;
    unique case (state_q)
      S_ACTIVE: begin
        CPU_CYCLE = ~kind_reg_q;
        REG_CYCLE = kind_reg_q;
      end
      S_LATCH: begin
        CPU_CYCLE = ~kind_reg_q;
        REG_CYCLE = kind_reg_q;
        RD_LATCH  = rnw_q;
      end
      S_DONE:  DONE = 1'b1;
      default: ;
    endcase
  end

  assign CPU_RnW = rnw_q;
  assign STARVE  = starve_q;

endmodule

// File: tb/tb_u712_chip_cycle_seq.sv
// Randomized bench for u712_chip_cycle_seq against a slot/timeline reference model.
module tb_u712_chip_cycle_seq;

  localparam int SYNC = 2;
  localparam int ACT  = 16;
  localparam int MAXW = 8;

  logic CLK80, RESETn, C1, DBRn, CHIP_REQ, REG_REQ, RnW;
  logic CPU_CYCLE, REG_CYCLE, CPU_RnW, RD_LATCH, DONE, STARVE;

  u712_chip_cycle_seq #(
    .SYNC_STAGES   (SYNC),
    .ACTIVE_CLKS   (ACT),
    .MAX_WAIT_SLOTS(MAXW)
  ) dut (
    .CLK80    (CLK80),
    .RESETn   (RESETn),
    .C1       (C1),
    .DBRn     (DBRn),
    .CHIP_REQ (CHIP_REQ),
    .REG_REQ  (REG_REQ),
    .RnW      (RnW),
    .CPU_CYCLE(CPU_CYCLE),
    .REG_CYCLE(REG_CYCLE),
    .CPU_RnW  (CPU_RnW),
    .RD_LATCH (RD_LATCH),
    .DONE     (DONE),
    .STARVE   (STARVE)
  );

  initial CLK80 = 1'b0;
  always #5 CLK80 = ~CLK80;

  typedef struct {
    int   e;
    logic dbr;
  } slot_t;

  slot_t slot_q[$];
  int    edge_n;
  int    c1_ph, c1_per;
  bit    deny_en;
  int    deny_target;
  int    n_tests, n_fail;

  bit         m_busy;
  int         m_idle_from, m_accept, m_start, m_denied, m_starve_edge, m_txn;
  logic       m_kind_reg, m_rnw, m_starve, m_c1_prev;
  logic [5:0] exp_vec;

  int         r_mism, r_cpu_hi, r_reg_hi, r_rdl, r_done, r_both, r_rnw_bad;
  int         r_first_hi, r_starve_edge, r_mis_edge;
  bit         r_timeout;
  logic [5:0] r_mis_got, r_mis_exp;

  function automatic void model_reset();
    m_busy = 0; m_idle_from = 0; m_accept = 0; m_start = -1; m_denied = 0;
    m_kind_reg = 0; m_rnw = 0; m_starve = 0; m_c1_prev = 0;
    slot_q.delete();
    exp_vec = '0;
  endfunction

  function automatic void model_edge();
    slot_t s;
    bit    act, ecyc, erd, edn;
    if (C1 && !m_c1_prev) slot_q.push_back('{e: edge_n + SYNC, dbr: DBRn});
    m_c1_prev = C1;
    if (!m_busy && edge_n >= m_idle_from && (CHIP_REQ || REG_REQ)) begin
      m_busy = 1; m_txn++; m_accept = edge_n; m_kind_reg = REG_REQ; m_rnw = RnW;
      m_start = -1; m_denied = 0; m_starve_edge = -1;
    end
    while (slot_q.size() > 0 && slot_q[0].e <= edge_n) begin
      s = slot_q.pop_front();
      if (s.e == edge_n && m_busy && m_start < 0 && edge_n > m_accept) begin
        if (s.dbr) m_start = edge_n;
        else begin
          if (m_denied < 255) m_denied++;
          if (m_denied >= MAXW && !m_starve) begin
            m_starve = 1; m_starve_edge = edge_n;
          end
        end
      end
    end
    act  = m_busy && m_start >= 0;
    ecyc = act && edge_n >= m_start && edge_n <= m_start + ACT;
    erd  = act && edge_n == m_start + ACT && m_rnw;
    edn  = act && edge_n == m_start + ACT + 1;
    if (edn) begin
      m_starve = 0; m_busy = 0; m_denied = 0; m_idle_from = edge_n + 2;
    end
    exp_vec = {ecyc && !m_kind_reg, ecyc && m_kind_reg, m_rnw, erd, edn, m_starve};
  endfunction

  task automatic step();
    @(negedge CLK80);
    c1_ph = c1_ph + 1;
    if (c1_ph >= c1_per) begin
      c1_ph  = 0;
      c1_per = $urandom_range(8, 14);
    end
    C1 = (c1_ph < c1_per / 2);
    if (c1_ph == 0 && deny_en) DBRn = (m_denied < deny_target) ? 1'b0 : 1'b1;
    else DBRn = 1'($urandom_range(0, 1));
    @(posedge CLK80);
    edge_n++;
    if (RESETn !== 1'b1) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic run_txn(input logic rq_reg, input logic rq_chip, input logic rq_rnw,
                         input int deny_n, input int drop_at);
    int         txn0, k;
    bit         fin;
    logic [5:0] obs;
    r_mism = 0; r_cpu_hi = 0; r_reg_hi = 0; r_rdl = 0; r_done = 0; r_both = 0;
    r_rnw_bad = 0; r_first_hi = -1; r_starve_edge = -1; r_mis_edge = -1;
    r_mis_got = '0; r_mis_exp = '0; r_timeout = 0;
    deny_en = 1; deny_target = deny_n;
    REG_REQ = rq_reg; CHIP_REQ = rq_chip; RnW = rq_rnw;
    txn0 = m_txn; k = 0; fin = 0;
    for (int c = 0; c < 800 && !fin; c++) begin
      step();
      obs = {CPU_CYCLE, REG_CYCLE, CPU_RnW, RD_LATCH, DONE, STARVE};
      if (obs !== exp_vec) begin
        if (r_mism == 0) begin
          r_mis_edge = edge_n; r_mis_got = obs; r_mis_exp = exp_vec;
        end
        r_mism++;
      end
      if (CPU_CYCLE === 1'b1) r_cpu_hi++;
      if (REG_CYCLE === 1'b1) r_reg_hi++;
      if (RD_LATCH === 1'b1) r_rdl++;
      if (DONE === 1'b1) r_done++;
      if (CPU_CYCLE === 1'b1 && REG_CYCLE === 1'b1) r_both++;
      if (STARVE === 1'b1 && r_starve_edge < 0) r_starve_edge = edge_n;
      if ((CPU_CYCLE === 1'b1 || REG_CYCLE === 1'b1) && r_first_hi < 0) r_first_hi = edge_n;
      if ((CPU_CYCLE || REG_CYCLE || RD_LATCH || DONE) && CPU_RnW !== rq_rnw) r_rnw_bad++;
      if (m_txn != txn0) begin
        k++;
        if (k == drop_at) begin
          CHIP_REQ = 0; REG_REQ = 0;
        end
        if (DONE === 1'b1 || exp_vec[1]) begin
          CHIP_REQ = 0; REG_REQ = 0;
        end
        if (!m_busy) fin = 1;
      end
    end
    if (!fin) r_timeout = 1;
    CHIP_REQ = 0; REG_REQ = 0; deny_en = 0;
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    RESETn = 0; CHIP_REQ = 1; REG_REQ = 0; RnW = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      obs = {CPU_CYCLE, REG_CYCLE, CPU_RnW, RD_LATCH, DONE, STARVE};
      n_tests++;
      if (obs !== 6'b0) begin
        n_fail++; $display("FAIL reset_hold: outputs got %b expected %b", obs, 6'b0);
      end
    end
    CHIP_REQ = 0; RESETn = 1;
    step();
    obs = {CPU_CYCLE, REG_CYCLE, CPU_RnW, RD_LATCH, DONE, STARVE};
    n_tests++;
    if (obs !== 6'b0) begin
      n_fail++; $display("FAIL reset_release: outputs got %b expected %b", obs, 6'b0);
    end
  endtask

  task automatic test_chip_read();
    run_txn(1'b0, 1'b1, 1'b1, 0, -1);
    n_tests += 7;
    if (r_timeout !== 0) begin n_fail++; $display("FAIL chip_read timeout: got %0d expected 0", r_timeout); end
    if (r_mism !== 0) begin n_fail++; $display("FAIL chip_read trace: %0d bad cycles, first edge %0d got %b expected %b", r_mism, r_mis_edge, r_mis_got, r_mis_exp); end
    if (r_cpu_hi !== ACT + 1) begin n_fail++; $display("FAIL chip_read cpu_hi: got %0d expected %0d", r_cpu_hi, ACT + 1); end
    if (r_reg_hi !== 0) begin n_fail++; $display("FAIL chip_read reg_hi: got %0d expected 0", r_reg_hi); end
    if (r_rdl !== 1) begin n_fail++; $display("FAIL chip_read rd_latch: got %0d expected 1", r_rdl); end
    if (r_done !== 1) begin n_fail++; $display("FAIL chip_read done: got %0d expected 1", r_done); end
    if (r_rnw_bad !== 0) begin n_fail++; $display("FAIL chip_read cpu_rnw: %0d cycles wrong, expected 0", r_rnw_bad); end
  endtask

  task automatic test_reg_write();
    run_txn(1'b1, 1'b0, 1'b0, 0, -1);
    n_tests += 6;
    if (r_mism !== 0) begin n_fail++; $display("FAIL reg_write trace: %0d bad cycles, first edge %0d got %b expected %b", r_mism, r_mis_edge, r_mis_got, r_mis_exp); end
    if (r_reg_hi !== ACT + 1) begin n_fail++; $display("FAIL reg_write reg_hi: got %0d expected %0d", r_reg_hi, ACT + 1); end
    if (r_cpu_hi !== 0) begin n_fail++; $display("FAIL reg_write cpu_hi: got %0d expected 0", r_cpu_hi); end
    if (r_rdl !== 0) begin n_fail++; $display("FAIL reg_write rd_latch: got %0d expected 0", r_rdl); end
    if (r_done !== 1) begin n_fail++; $display("FAIL reg_write done: got %0d expected 1", r_done); end
    if (CPU_RnW !== 1'b0) begin n_fail++; $display("FAIL reg_write rnw_hold: got %b expected 0", CPU_RnW); end
  endtask

  task automatic test_dma_contention();
    run_txn(1'b0, 1'b1, 1'b1, 10, -1);
    n_tests += 5;
    if (r_mism !== 0) begin n_fail++; $display("FAIL dma trace: %0d bad cycles, first edge %0d got %b expected %b", r_mism, r_mis_edge, r_mis_got, r_mis_exp); end
    if (r_starve_edge < 0) begin n_fail++; $display("FAIL dma starve_seen: got %0d expected >=0", r_starve_edge); end
    if (r_starve_edge !== m_starve_edge) begin n_fail++; $display("FAIL dma starve_edge: got %0d expected %0d", r_starve_edge, m_starve_edge); end
    if (STARVE !== 1'b0) begin n_fail++; $display("FAIL dma starve_clear: got %b expected 0", STARVE); end
    if (r_done !== 1) begin n_fail++; $display("FAIL dma done: got %0d expected 1", r_done); end
  endtask

  task automatic test_req_drop();
    run_txn(1'b0, 1'b1, 1'b0, 2, 3);
    n_tests += 3;
    if (r_mism !== 0) begin n_fail++; $display("FAIL req_drop trace: %0d bad cycles, first edge %0d got %b expected %b", r_mism, r_mis_edge, r_mis_got, r_mis_exp); end
    if (r_cpu_hi !== ACT + 1) begin n_fail++; $display("FAIL req_drop cpu_hi: got %0d expected %0d", r_cpu_hi, ACT + 1); end
    if (r_done !== 1) begin n_fail++; $display("FAIL req_drop done: got %0d expected 1", r_done); end
  endtask

  task automatic test_both_req();
    run_txn(1'b1, 1'b1, 1'b1, 0, -1);
    n_tests += 4;
    if (r_reg_hi !== ACT + 1) begin n_fail++; $display("FAIL both_req reg_hi: got %0d expected %0d", r_reg_hi, ACT + 1); end
    if (r_cpu_hi !== 0) begin n_fail++; $display("FAIL both_req cpu_hi: got %0d expected 0", r_cpu_hi); end
    if (r_both !== 0) begin n_fail++; $display("FAIL both_req exclusive: got %0d expected 0", r_both); end
    if (r_rdl !== 1) begin n_fail++; $display("FAIL both_req rd_latch: got %0d expected 1", r_rdl); end
  endtask

  task automatic test_slot_coincide();
    int coinc;
    bit found;
    deny_en = 1; deny_target = 0; found = 0; coinc = -1;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (!m_busy && edge_n + 1 >= m_idle_from && slot_q.size() > 0 && slot_q[0].e == edge_n + 1
          && slot_q[0].dbr === 1'b1) begin
        found = 1; coinc = edge_n + 1;
      end
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL coincide align: got %0d expected 1", found); end
    run_txn(1'b0, 1'b1, 1'b1, 0, -1);
    n_tests += 3;
    if (r_mism !== 0) begin n_fail++; $display("FAIL coincide trace: %0d bad cycles, first edge %0d got %b expected %b", r_mism, r_mis_edge, r_mis_got, r_mis_exp); end
    if (r_first_hi <= coinc) begin n_fail++; $display("FAIL coincide skip: start edge %0d expected after %0d", r_first_hi, coinc); end
    if (r_first_hi !== m_start) begin n_fail++; $display("FAIL coincide start: got %0d expected %0d", r_first_hi, m_start); end
  endtask

  task automatic test_random();
    logic rq_reg, rq_chip;
    for (int i = 0; i < 15; i++) begin
      rq_reg  = 1'($urandom_range(0, 1));
      rq_chip = rq_reg ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(rq_reg, rq_chip, 1'($urandom_range(0, 1)), $urandom_range(0, 12),
              ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : -1);
      n_tests += 4;
      if (r_timeout !== 0) begin n_fail++; $display("FAIL random[%0d] timeout: got %0d expected 0", i, r_timeout); end
      if (r_mism !== 0) begin n_fail++; $display("FAIL random[%0d] trace: %0d bad cycles, first edge %0d got %b expected %b", i, r_mism, r_mis_edge, r_mis_got, r_mis_exp); end
      if (r_both !== 0) begin n_fail++; $display("FAIL random[%0d] exclusive: got %0d expected 0", i, r_both); end
      if (r_done !== 1) begin n_fail++; $display("FAIL random[%0d] done: got %0d expected 1", i, r_done); end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] obs;
    bit got;
    deny_en = 1; deny_target = 0; CHIP_REQ = 1; REG_REQ = 0; RnW = 1; got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      step();
      if (m_busy && m_start >= 0 && edge_n >= m_start + 3) got = 1;
    end
    n_tests += 2;
    if (!got) begin n_fail++; $display("FAIL reset_mid reach_active: got %0d expected 1", got); end
    if (CPU_CYCLE !== 1'b1) begin n_fail++; $display("FAIL reset_mid pre_cycle: got %b expected 1", CPU_CYCLE); end
    #2 RESETn = 0;
    #1;
    obs = {CPU_CYCLE, REG_CYCLE, CPU_RnW, RD_LATCH, DONE, STARVE};
    n_tests++;
    if (obs !== 6'b0) begin n_fail++; $display("FAIL reset_mid async_clear: got %b expected %b", obs, 6'b0); end
    CHIP_REQ = 0; deny_en = 0;
    step();
    step();
    RESETn = 1;
    step();
    obs = {CPU_CYCLE, REG_CYCLE, CPU_RnW, RD_LATCH, DONE, STARVE};
    n_tests++;
    if (obs !== 6'b0) begin n_fail++; $display("FAIL reset_mid after_release: got %b expected %b", obs, 6'b0); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    n_tests = 0; n_fail = 0; edge_n = 0; m_txn = 0; m_starve_edge = -1;
    c1_ph = 0; c1_per = 10; deny_en = 0; deny_target = 0;
    RESETn = 0; C1 = 0; DBRn = 1; CHIP_REQ = 0; REG_REQ = 0; RnW = 0;
    model_reset();
    test_reset();
    test_chip_read();
    test_reg_write();
    test_dma_contention();
    test_req_drop();
    test_both_req();
    test_slot_coincide();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/u712_chip_cycle_seq.md
Name: u712_chip_cycle_seq

Overview:
- CPU-side initiator for chip bus accesses, i.e. it produces the cycle signals that the chipset buffer-enable logic consumes.
- Accepts a CPU request for chip RAM or a chipset register, waits for a free (non-DMA) 7 MHz slot, then asserts CPU_CYCLE or REG_CYCLE for a fixed window.
- Produces a read-data latch strobe and a one-clock completion pulse back to the CPU bus controller.
- Sits in U712 between the CPU address decode and the buffer/RAS-CAS logic.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for C1 and DBRn.
- ACTIVE_CLKS, 16, CLK80 cycles that CPU_CYCLE/REG_CYCLE stay asserted in ACTIVE; legal range 2..63.
- MAX_WAIT_SLOTS, 8, consecutive DMA-owned slots before STARVE asserts; legal range 1..255.

Ports:
- CLK80  input  1  system clock; all logic rises on it.
- RESETn  input  1  asynchronous, active-low reset.
- C1  input  1  Amiga 7 MHz colour-clock phase, asynchronous; its rising edge marks a slot boundary.
- DBRn  input  1  Agnus DMA bus request, asynchronous; low means the coming slot belongs to DMA.
- CHIP_REQ  input  1  CPU requests a chip RAM access; level signal, held until DONE.
- REG_REQ  input  1  CPU requests a chipset register access; level signal, held until DONE.
- RnW  input  1  direction of the CPU access; 1 = read.
- CPU_CYCLE  output  1  CPU chip RAM cycle active.
- REG_CYCLE  output  1  CPU register cycle active.
- CPU_RnW  output  1  RnW registered at request acceptance, stable for the whole cycle.
- RD_LATCH  output  1  one-clock pulse to capture read data.
- DONE  output  1  one-clock completion pulse.
- STARVE  output  1  DMA starvation flag.

Behaviour:
- Reset: while RESETn is low, state = IDLE and all outputs = 0, including CPU_RnW. The synchronisers, slot counter and active counter clear to 0.
- Reset asserted mid-cycle clears all outputs immediately, without waiting for CLK80. Cycle-active signals go low at once.
- Synchronisation: C1 and DBRn pass through SYNC_STAGES flops. SLOT = rising edge of synchronised C1 (sync_C1 = 1 and previous = 0), one CLK80 wide.
- IDLE:
  - If REG_REQ or CHIP_REQ is high, latch kind and RnW into CPU_RnW, then go to WAIT.
  - REG_REQ has priority if both are high, so kind = REG.
- WAIT:
  - On SLOT with sync DBRn = 1: go to ACTIVE.
  - On SLOT with sync DBRn = 0: increment the wait-slot counter, saturating at 255.
  - A request accepted on the same clock as a SLOT does not use that slot. The earliest usable slot is the next SLOT.
- ACTIVE:
  - Assert REG_CYCLE (kind REG) or CPU_CYCLE (kind CHIP); never both.
  - The active counter counts from 0 to ACTIVE_CLKS-1, so assertion lasts exactly ACTIVE_CLKS clocks starting the clock after SLOT.
  - At the final count go to LATCH.
- LATCH:
  - The cycle signal stays high.
  - RD_LATCH = 1 for this one clock, only if CPU_RnW = 1.
  - Next state is DONE.
- DONE:
  - The cycle signal drops.
  - DONE = 1 for one clock; STARVE and the counters clear.
  - Next state is IDLE.
  - The request must be released at DONE. A request still high in IDLE on the following clock starts a new cycle.
- Total cycle-signal assertion: ACTIVE_CLKS+1 clocks (ACTIVE plus LATCH).
- STARVE is set when the wait-slot counter reaches MAX_WAIT_SLOTS. It stays sticky until DONE or reset. It is informational only and does not abort or force the cycle.
- Request dropped after acceptance: the cycle runs to completion, because a chip bus cycle cannot be aborted. DONE still pulses.
- DBRn changing during ACTIVE is ignored; the slot is committed at SLOT.
- CPU_RnW is constant from acceptance through DONE, then holds its value in IDLE.
- Illegal combination: CPU_CYCLE and REG_CYCLE must never both be high.

Test Plan:
- Reset: hold RESETn = 0 with CHIP_REQ = 1 -> all outputs 0. Assert RESETn = 0 in mid-ACTIVE -> CPU_CYCLE falls before the next CLK80 edge.
- Free slot, chip read: CHIP_REQ = 1, RnW = 1, DBRn = 1 -> at first usable SLOT, CPU_CYCLE high for 17 clocks, RD_LATCH on the 17th, DONE on the next clock, CPU_RnW = 1 throughout.
- Register write: REG_REQ = 1, RnW = 0 -> REG_CYCLE high for 17 clocks, CPU_CYCLE = 0, no RD_LATCH, DONE = 1 once.
- DMA contention: DBRn = 0 for 10 slots, then 1 -> STARVE rises at the 8th denied slot, cycle starts at slot 11, STARVE clears with DONE.
- Request dropped: CHIP_REQ deasserted 3 clocks into WAIT -> cycle still executes and DONE pulses. Both REG_REQ and CHIP_REQ = 1 -> only REG_CYCLE asserts.
- Slot coincidence: request rises on the same clock as SLOT -> that slot is skipped, cycle starts on the following SLOT.
